// File: rtl/min_sec_compose_pkg.sv
// ============================================================================
// Module : min_sec_compose_pkg
// Brief  : Shared widths, FSM encoding, digit-select codes and BCD helper
//          for the mm:ss time-entry block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package min_sec_compose_pkg;

  localparam int c_bcd_counter_bits = 13;
  localparam int c_seg7_input_bits  = 4;

  typedef enum logic [1:0] {
    MSC_IDLE = 2'd0,
    MSC_EDIT = 2'd1,
    MSC_CALC = 2'd2,
    MSC_OUT  = 2'd3
  } msc_state_e;

  localparam logic [1:0] c_sel_d0_sec = 2'd0;
  localparam logic [1:0] c_sel_d1_sec = 2'd1;
  localparam logic [1:0] c_sel_d0_min = 2'd2;
  localparam logic [1:0] c_sel_d1_min = 2'd3;

  // Two-digit BCD to binary; 99 fits in 7 bits.
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

`default_nettype wire

// File: rtl/min_sec_digit.sv
// ============================================================================
// Module : min_sec_digit
// Brief  : One wrapping BCD digit register (modulo MOD), no carry or borrow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module min_sec_digit #(
  parameter int MOD      = 10,
  parameter int DIG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [DIG_BITS-1:0] digit_o
);

  localparam logic [DIG_BITS-1:0] c_max = DIG_BITS'(MOD - 1);

  logic [DIG_BITS-1:0] digit_q;
  logic [DIG_BITS-1:0] digit_d;

  always_comb begin
    digit_d = digit_q;
    if (inc_i) begin
      digit_d = (digit_q == c_max) ? '0 : digit_q + DIG_BITS'(1);
    end else if (dec_i) begin
      digit_d = (digit_q == '0) ? c_max : digit_q - DIG_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit_o = digit_q;

endmodule

`default_nettype wire

// File: rtl/min_sec_compose.sv
// ============================================================================
// Module : min_sec_compose
// Brief  : mm:ss digit editor with commit to binary total seconds.
//          Optional macro MIN_SEC_DEC_EN enables the decrement button.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module min_sec_compose
  import min_sec_compose_pkg::*;
#(
  parameter int CNT_BITS = c_bcd_counter_bits,
  parameter int DIG_BITS = c_seg7_input_bits
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_set_i,
  input  logic                btn_next_i,
  input  logic                btn_inc_i,
  input  logic                btn_dec_i,
  input  logic                btn_done_i,
  output logic [DIG_BITS-1:0] d0_sec_o,
  output logic [DIG_BITS-1:0] d1_sec_o,
  output logic [DIG_BITS-1:0] d0_min_o,
  output logic [DIG_BITS-1:0] d1_min_o,
  output logic [1:0]          sel_o,
  output logic                setting_o,
  output logic [CNT_BITS-1:0] value_o,
  output logic                value_valid_o
);

  msc_state_e          state_q, state_d;
  logic [1:0]          sel_q;
  logic [6:0]          mins_q;
  logic [5:0]          secs_q;
  logic [CNT_BITS-1:0] value_q;
  logic                valid_q;

  logic                w_dec_btn;
  logic                w_inc_act, w_dec_act, w_next_act;
  logic [3:0]          w_inc, w_dec;
  logic [DIG_BITS-1:0] w_digit [4];

`ifdef MIN_SEC_DEC_EN
  assign w_dec_btn = btn_dec_i;
`else
  logic w_unused_dec;
  assign w_unused_dec = btn_dec_i;
  assign w_dec_btn    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= MSC_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MSC_IDLE: if (en_set_i)   state_d = MSC_EDIT;
      MSC_EDIT: if (btn_done_i) state_d = MSC_CALC;
      MSC_CALC: state_d = MSC_OUT;
      MSC_OUT:  state_d = MSC_IDLE;
      default:  state_d = MSC_IDLE;
    endcase
  end

  // Edit actions are mutually exclusive: done > inc > dec > next.
  always_comb begin
    setting_o  = (state_q == MSC_EDIT);
    w_inc_act  = setting_o && !btn_done_i && btn_inc_i;
    w_dec_act  = setting_o && !btn_done_i && !btn_inc_i && w_dec_btn;
    w_next_act = setting_o && !btn_done_i && !btn_inc_i && !w_dec_btn && btn_next_i;
    for (int i = 0; i < 4; i++) begin
      w_inc[i] = w_inc_act && (sel_q == 2'(i));
      w_dec[i] = w_dec_act && (sel_q == 2'(i));
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    min_sec_digit #(
      .MOD      ((gi == 1) ? 6 : 10),
      .DIG_BITS (DIG_BITS)
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (w_inc[gi]),
      .dec_i   (w_dec[gi]),
      .digit_o (w_digit[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= c_sel_d0_sec;
      mins_q  <= '0;
      secs_q  <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q == MSC_IDLE && en_set_i) sel_q <= c_sel_d0_sec;
      else if (w_next_act)                  sel_q <= sel_q + 2'd1;
      if (state_q == MSC_CALC) begin
        mins_q <= bcd2bin(4'(w_digit[c_sel_d1_min]), 4'(w_digit[c_sel_d0_min]));
        secs_q <= 6'(bcd2bin(4'(w_digit[c_sel_d1_sec]), 4'(w_digit[c_sel_d0_sec])));
      end
      if (state_q == MSC_OUT) begin
        value_q <= CNT_BITS'(mins_q) * CNT_BITS'(60) + CNT_BITS'(secs_q);
        valid_q <= 1'b1;
      end
    end
  end

  assign d0_sec_o      = w_digit[c_sel_d0_sec];
  assign d1_sec_o      = w_digit[c_sel_d1_sec];
  assign d0_min_o      = w_digit[c_sel_d0_min];
  assign d1_min_o      = w_digit[c_sel_d1_min];
  assign sel_o         = sel_q;
  assign value_o       = value_q;
  assign value_valid_o = valid_q;

endmodule

`default_nettype wire
